// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer.
// State encodings and default width.
package countdown_timer_pkg;

  localparam int unsigned CT_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/countdown_timer_reg.sv
// WIDTH-bit register with async clear.
// Select: load, decrement, or hold.
module countdown_reg
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = CT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // load wins over decrement; otherwise hold
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (dec) begin
      q_d = q_q - WIDTH'(1);
    end
  end

  // value register, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with done pulse,
// pause/abort control and optional auto-reload.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = CT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  state_e           state_d;
  state_e           state_q;
  logic             done_d;
  logic             done_q;
  logic             cnt_ld;
  logic             cnt_dec;
  logic [WIDTH-1:0] cnt_val;
  logic             rel_ld;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;

  countdown_reg #(.WIDTH(WIDTH)) u_count (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_ld),
    .dec     (cnt_dec),
    .d       (cnt_val),
    .q       (count_q)
  );

  countdown_reg #(.WIDTH(WIDTH)) u_reload (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (rel_ld),
    .dec     (1'b0),
    .d       (load_value),
    .q       (reload_q)
  );

  // next state, counter controls and done
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    cnt_val = load_value;
    rel_ld  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          cnt_ld = 1'b1;
          rel_ld = 1'b1;
        end
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else if (count_q <= WIDTH'(1)) begin
          // terminal at 1 (or 0) so 0 never wraps
          done_d = 1'b1;
          cnt_ld = 1'b1;
          if (auto_reload) begin
            cnt_val = reload_q;
          end else begin
            cnt_val = '0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and done registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign count  = count_q;
  assign busy   = (state_q == ST_RUN) ||
                  (state_q == ST_HOLD);
  assign paused = (state_q == ST_HOLD);
  assign done   = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed steps,
// random traffic and a behavioural model.
module tb_countdown_timer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         paused;
  logic         done;

  int errors = 0;
  int checks = 0;

  // behavioural model of the timer
  int m_cnt  = 0;
  int m_rel  = 0;
  bit m_busy = 0;
  bit m_hold = 0;
  bit m_done = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .paused      (paused),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_rel  = 0;
    m_busy = 0;
    m_hold = 0;
    m_done = 0;
  endtask

  // one clock edge of the timer's rules
  task automatic model_edge(input bit ld,
                            input int lv,
                            input bit st,
                            input bit pa,
                            input bit ab,
                            input bit ar);
    bit nd;
    nd = 0;
    if (!m_busy) begin
      if (ld) begin
        m_cnt = lv;
        m_rel = lv;
      end
      if (st) m_busy = 1;
    end else if (m_hold) begin
      if (ab) begin
        m_busy = 0;
        m_hold = 0;
      end else if (!pa) begin
        m_hold = 0;
      end
    end else if (ab) begin
      m_busy = 0;
    end else if (pa) begin
      m_hold = 1;
    end else if (m_cnt <= 1) begin
      nd = 1;
      if (ar) begin
        m_cnt = m_rel;
      end else begin
        m_cnt  = 0;
        m_busy = 0;
      end
    end else begin
      m_cnt = m_cnt - 1;
    end
    m_done = nd;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_cnt));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".paused"}, 32'(paused), 32'(m_hold));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  task automatic cyc(input bit ld,
                     input int lv,
                     input bit st,
                     input bit pa,
                     input bit ab,
                     input bit ar);
    @(negedge clk);
    load        = ld;
    load_value  = W'(lv);
    start       = st;
    pause       = pa;
    abort       = ab;
    auto_reload = ar;
    @(posedge clk);
    model_edge(ld, lv, st, pa, ab, ar);
    #1;
    chk_all("cyc");
  endtask

  // edges until done, bounded
  task automatic wait_done(input bit ar,
                           output int k);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 0, ar);
      k++;
      if (done === 1'b1) break;
    end
  endtask

  int k;

  initial begin
    #2;
    chk("rst.count", 32'(count), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.paused", 32'(paused), 0);
    chk("rst.done", 32'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // load 5, start, count to expiry
    cyc(1, 5, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("n5.busy", 32'(busy), 1);
    wait_done(0, k);
    chk("n5.latency", 32'(k), 5);
    chk("n5.idle", 32'(busy), 0);

    // zero and one both expire after one edge
    cyc(1, 0, 1, 0, 0, 0);
    wait_done(0, k);
    chk("n0.latency", 32'(k), 1);
    cyc(1, 1, 1, 0, 0, 0);
    wait_done(0, k);
    chk("n1.latency", 32'(k), 1);

    // periodic with reload 3
    cyc(1, 3, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++)
      cyc(0, 0, 0, 0, 0, 1);
    chk("ar.done9", 32'(done), 1);
    chk("ar.count9", 32'(count), 3);
    wait_done(0, k);
    chk("ar.stop", 32'(k), 3);
    chk("ar.zero", 32'(count), 0);

    // pause at 4 for four edges
    cyc(1, 6, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pa.at4", 32'(count), 4);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 1, 0, 0);
    chk("pa.held", 32'(paused), 1);
    wait_done(0, k);
    chk("pa.latency", 32'(2 + 4 + k), 6 + 5);

    // abort at 3
    cyc(1, 7, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("ab.count", 32'(count), 3);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 0, 0);

    // abort beats pause, and abort from hold
    cyc(1, 7, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("abpa.busy", 32'(busy), 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // async reset between edges at count 2
    cyc(1, 4, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ar2.count", 32'(count), 2);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("async");
    reset_n = 1'b1;

    // reload cleared: done every cycle
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);

    // load and start ignored while busy
    cyc(1, 5, 1, 0, 0, 1);
    cyc(1, 2, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 1);
    wait_done(1, k);
    chk("busy.reload", 32'(count), 5);
    cyc(0, 0, 0, 0, 1, 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(3) == 0,
          int'($urandom_range(7)),
          $urandom_range(3) == 0,
          $urandom_range(5) == 0,
          $urandom_range(9) == 0,
          $urandom_range(1) == 1);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
